// File: rtl/fcvt_pkg.sv
// Shared definitions for the binary32 -> int32/uint32 sequential converter:
// FSM states, operand classes, rounding-mode encodings, saturation values
// and fflags bit positions.
package fcvt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_SHIFT,
    ST_ROUND,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO,   // zero or denormal
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } cls_t;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [31:0] SAT_S_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_S_MIN = 32'h8000_0000;
  localparam logic [31:0] SAT_U_MAX = 32'hFFFF_FFFF;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

endpackage

// File: rtl/f2i_round.sv
// Rounding-increment decision: given the sign, the integer lsb and the
// guard/round/sticky bits, decide whether the magnitude gets +1.
module f2i_round
  import fcvt_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       r,
  input  logic       s,
  input  logic [2:0] rm,
  output logic       inc
);

  // Increment rule per rounding mode; unknown encodings truncate like RTZ.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = g & (r | s | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | r | s);
      RM_RUP:  inc = ~sign & (g | r | s);
      RM_RMM:  inc = g;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/float2int_seq.sv
// Sequential FCVT.W.S / FCVT.WU.S: IDLE -> UNPACK -> SHIFT -> ROUND -> DONE,
// one state per cycle, result held in DONE until out_ready.
// Optional macro FCVT_FFLAGS_EN enables NV/NX flag generation; without it
// fflags is tied to zero.
module float2int_seq
  import fcvt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] float_in,
  input  logic        is_unsigned,
  input  logic [2:0]  rm,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic [4:0]  fflags
);

  state_t      state, state_nxt;

  logic [31:0] op_f;
  logic        op_uns;
  logic [2:0]  op_rm;

  logic        u_sign;
  logic [7:0]  u_exp;
  logic [23:0] u_mant;
  cls_t        u_cls;

  logic [31:0] s_int;
  logic        s_g, s_r, s_s, s_big;

  cls_t        cls_d;
  logic [7:0]  sh_amt;
  logic [95:0] wide;
  logic [31:0] int_d;
  logic        g_d, r_d, s_d, big_d;

  logic        inc;
  logic [32:0] mag;
  logic [31:0] conv;
  logic        sat;
  logic [31:0] sat_val;
  logic [31:0] res_int;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Next-state logic; flush overrides any accept or consume.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (in_valid) state_nxt = ST_UNPACK;
      ST_UNPACK: state_nxt = ST_SHIFT;
      ST_SHIFT:  state_nxt = ST_ROUND;
      ST_ROUND:  state_nxt = ST_DONE;
      ST_DONE:   if (out_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Operand classification from the captured operand.
  always_comb begin
    cls_d = CLS_NORM;
    if (op_f[30:23] == 8'hFF)      cls_d = (op_f[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
    else if (op_f[30:23] == 8'h00) cls_d = CLS_ZERO;
  end

  // Place the significand so bit 64 is weight 2^0: [95:64] integer part,
  // bit 63 guard, bit 62 round, [61:0] sticky. Exponents 125..158 fit.
  always_comb begin
    sh_amt = u_exp - 8'd86;
    wide   = {72'd0, u_mant} << sh_amt;
    int_d  = '0;
    g_d    = 1'b0;
    r_d    = 1'b0;
    s_d    = 1'b0;
    big_d  = 1'b0;
    if (u_exp >= 8'd159) begin
      big_d = 1'b1;                        // |x| >= 2^32, also inf/NaN
    end else if (u_exp >= 8'd125) begin
      {int_d, g_d, r_d} = wide[95:62];
      s_d = |wide[61:0];
    end else begin
      s_d = |u_mant;                       // below 0.25: only sticky survives
    end
  end

  f2i_round u_round (
    .sign (u_sign),
    .lsb  (s_int[0]),
    .g    (s_g),
    .r    (s_r),
    .s    (s_s),
    .rm   (op_rm),
    .inc  (inc)
  );

  // Round, negate and saturate. Zero/denormal inputs never round away from 0.
  always_comb begin
    mag     = {1'b0, s_int} + {32'd0, inc & (u_cls == CLS_NORM)};
    conv    = u_sign ? (~mag[31:0] + 32'd1) : mag[31:0];
    sat     = 1'b0;
    sat_val = '0;
    if (u_cls == CLS_NAN) begin
      sat     = 1'b1;
      sat_val = op_uns ? SAT_U_MAX : SAT_S_MAX;
    end else if (op_uns) begin
      if (!u_sign) begin
        sat     = s_big | mag[32];
        sat_val = SAT_U_MAX;
      end else begin
        sat     = s_big | (mag != 33'd0);
        sat_val = '0;
      end
    end else begin
      if (!u_sign) begin
        sat     = s_big | mag[32] | mag[31];
        sat_val = SAT_S_MAX;
      end else begin
        sat     = s_big | (mag > 33'h0_8000_0000);
        sat_val = SAT_S_MIN;
      end
    end
    res_int = sat ? sat_val : conv;
  end

  // Pipeline-stage registers, advanced by the FSM; flush blocks any update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_f    <= '0;
      op_uns  <= 1'b0;
      op_rm   <= '0;
      u_sign  <= 1'b0;
      u_exp   <= '0;
      u_mant  <= '0;
      u_cls   <= CLS_ZERO;
      s_int   <= '0;
      s_g     <= 1'b0;
      s_r     <= 1'b0;
      s_s     <= 1'b0;
      s_big   <= 1'b0;
      int_out <= '0;
    end else if (!flush) begin
      case (state)
        ST_IDLE: if (in_valid) begin
          op_f   <= float_in;
          op_uns <= is_unsigned;
          op_rm  <= rm;
        end
        ST_UNPACK: begin
          u_sign <= op_f[31];
          u_exp  <= op_f[30:23];
          u_mant <= {op_f[30:23] != 8'h00, op_f[22:0]};
          u_cls  <= cls_d;
        end
        ST_SHIFT: begin
          s_int <= int_d;
          s_g   <= g_d;
          s_r   <= r_d;
          s_s   <= s_d;
          s_big <= big_d;
        end
        ST_ROUND: int_out <= res_int;
        default: ;
      endcase
    end
  end

`ifdef FCVT_FFLAGS_EN
  logic [4:0] flags_d;

  // NV on saturation; NX on discarded bits only when not invalid.
  always_comb begin
    flags_d          = '0;
    flags_d[FLAG_NV] = sat;
    flags_d[FLAG_DZ] = 1'b0;
    flags_d[FLAG_OF] = 1'b0;
    flags_d[FLAG_UF] = 1'b0;
    flags_d[FLAG_NX] = ~sat & (s_g | s_r | s_s);
  end

  // Flag register, written alongside int_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            fflags <= '0;
    else if (!flush && state == ST_ROUND) fflags <= flags_d;
  end
`else
  assign fflags = '0;
`endif

endmodule

// File: tb/tb_float2int_seq.sv
// Scoreboard bench for float2int_seq: the driver pushes hand-computed
// expectations on accept, a monitor pops and compares on each consume.
module tb_float2int_seq;
  import fcvt_pkg::*;

`ifdef FCVT_FFLAGS_EN
  localparam logic [4:0] FLAG_MASK = 5'h1F;
`else
  localparam logic [4:0] FLAG_MASK = 5'h00;
`endif
  localparam logic [4:0] ZERO_BITS = 5'((1 << FLAG_DZ) | (1 << FLAG_OF) | (1 << FLAG_UF));

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, is_unsigned, flush;
  logic        out_valid, out_ready;
  logic [31:0] float_in, int_out;
  logic [2:0]  rm;
  logic [4:0]  fflags;

  typedef struct {
    string       name;
    logic [31:0] i;
    logic [4:0]  f;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] f;
    logic        u;
    logic [2:0]  m;
    logic [31:0] i;
    logic        nv;
    logic        nx;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  float2int_seq dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .float_in    (float_in),
    .is_unsigned (is_unsigned),
    .rm          (rm),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .int_out     (int_out),
    .fflags      (fflags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [4:0] fl(input logic nv, input logic nx);
    logic [4:0] v;
    v = '0;
    v[FLAG_NV] = nv;
    v[FLAG_NX] = nx;
    return v & FLAG_MASK;
  endfunction

  // Issue one operand (waiting for in_ready) and record its expectation.
  task automatic send(input string name, input logic [31:0] f, input logic u,
                      input logic [2:0] m, input logic [31:0] ei, input logic [4:0] ef);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check({name, "_in_ready_timeout"}, 0, 1);
      return;
    end
    float_in = f; is_unsigned = u; rm = m; in_valid = 1'b1;
    @(posedge clk);
    e.name = name; e.i = ei; e.f = ef;
    sb.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  // Accept an operand that will be aborted, so nothing is expected.
  task automatic accept_only(input logic [31:0] f);
    float_in = f; is_unsigned = 1'b0; rm = RM_RNE; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", (n < 200), 1);
  endtask

  task automatic watch_no_valid(input string name);
    logic seen;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check(name, seen, 0);
  endtask

  // Monitor: compare every consumed result against the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", int_out, 32'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          check({e.name, "_int"}, int_out, e.i);
          check({e.name, "_flags"}, fflags, e.f);
          check({e.name, "_zero_bits"}, fflags & ZERO_BITS, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs [23] = '{
    '{"r1p5_rne",   32'h3FC00000, 1'b0, RM_RNE, 32'd2,          1'b0, 1'b1},
    '{"r2p5_rne",   32'h40200000, 1'b0, RM_RNE, 32'd2,          1'b0, 1'b1},
    '{"r2p5_rmm",   32'h40200000, 1'b0, RM_RMM, 32'd3,          1'b0, 1'b1},
    '{"m1p5_rdn",   32'hBFC00000, 1'b0, RM_RDN, 32'hFFFFFFFE,   1'b0, 1'b1},
    '{"m1p5_rup",   32'hBFC00000, 1'b0, RM_RUP, 32'hFFFFFFFF,   1'b0, 1'b1},
    '{"r1p5_rup",   32'h3FC00000, 1'b0, RM_RUP, 32'd2,          1'b0, 1'b1},
    '{"p2_31_s",    32'h4F000000, 1'b0, RM_RTZ, 32'h7FFFFFFF,   1'b1, 1'b0},
    '{"m2_31_s",    32'hCF000000, 1'b0, RM_RTZ, 32'h80000000,   1'b0, 1'b0},
    '{"mbig_s",     32'hCF000001, 1'b0, RM_RTZ, 32'h80000000,   1'b1, 1'b0},
    '{"nan_u",      32'h7FC00000, 1'b1, RM_RTZ, 32'hFFFFFFFF,   1'b1, 1'b0},
    '{"m1_u",       32'hBF800000, 1'b1, RM_RTZ, 32'h00000000,   1'b1, 1'b0},
    '{"m0p3_u_rtz", 32'hBE99999A, 1'b1, RM_RTZ, 32'h00000000,   1'b0, 1'b1},
    '{"m0p5_u_rne", 32'hBF000000, 1'b1, RM_RNE, 32'h00000000,   1'b0, 1'b1},
    '{"p42_rtz",    32'h42280000, 1'b0, RM_RTZ, 32'd42,         1'b0, 1'b0},
    '{"m42_rne",    32'hC2280000, 1'b0, RM_RNE, 32'hFFFFFFD6,   1'b0, 1'b0},
    '{"p2_32_u",    32'h4F800000, 1'b1, RM_RNE, 32'hFFFFFFFF,   1'b1, 1'b0},
    '{"umax_u",     32'h4F7FFFFF, 1'b1, RM_RNE, 32'hFFFFFF00,   1'b0, 1'b0},
    '{"p2_31_u",    32'h4F000000, 1'b1, RM_RNE, 32'h80000000,   1'b0, 1'b0},
    '{"denorm_rup", 32'h00000001, 1'b0, RM_RUP, 32'd0,          1'b0, 1'b1},
    '{"zero",       32'h00000000, 1'b0, RM_RNE, 32'd0,          1'b0, 1'b0},
    '{"bad_rm",     32'h40200000, 1'b0, 3'b111, 32'd2,          1'b0, 1'b1},
    '{"ninf_s",     32'hFF800000, 1'b0, RM_RNE, 32'h80000000,   1'b1, 1'b0},
    '{"p0p5_rmm",   32'h3F000000, 1'b0, RM_RMM, 32'd1,          1'b0, 1'b1}
  };

  initial begin : stim
    int n;
    reset = 1'b1; in_valid = 1'b0; float_in = '0; is_unsigned = 1'b0;
    rm = RM_RNE; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_int_out", int_out, 0);
    check("rst_fflags", fflags, 0);
    reset = 1'b0;

    // Latency: accept edge, two quiet edges, then out_valid on the third.
    send("pi_rne", 32'h40490FDB, 1'b0, RM_RNE, 32'd3, fl(1'b0, 1'b1));
    repeat (2) begin
      @(posedge clk); #1;
      check("latency_early_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    check("latency_valid", out_valid, 1);
    drain();

    foreach (vecs[k])
      send(vecs[k].name, vecs[k].f, vecs[k].u, vecs[k].m, vecs[k].i, fl(vecs[k].nv, vecs[k].nx));
    drain();

    // Backpressure: result held stable for five cycles, in_ready low.
    out_ready = 1'b0;
    send("stall", 32'h40490FDB, 1'b0, RM_RNE, 32'd3, fl(1'b0, 1'b1));
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", out_valid, 1);
      check("stall_int", int_out, 32'd3);
      check("stall_flags", fflags, fl(1'b0, 1'b1));
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("consume_in_ready", in_ready, 1);
    check("consume_out_valid", out_valid, 0);

    // Flush while in SHIFT.
    accept_only(32'h42280000);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1);
    check("flush_out_valid", out_valid, 0);
    watch_no_valid("flush_no_valid");
    send("after_flush", 32'h3FC00000, 1'b0, RM_RNE, 32'd2, fl(1'b0, 1'b1));
    drain();

    // Reset asserted while in ROUND.
    accept_only(32'h42280000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_int_out", int_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_idle", in_ready, 1);
    watch_no_valid("midrst_no_valid");
    send("after_rst", 32'hC2280000, 1'b0, RM_RTZ, 32'hFFFFFFD6, fl(1'b0, 1'b0));
    drain();

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float2int_seq.md
FLOAT2INT_SEQ -- requirements
Module: float2int_seq

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1: operand request.
REQ-004 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-005 SHALL have port float_in, input, 32: IEEE-754 binary32 operand.
REQ-006 SHALL have port is_unsigned, input, 1: 0 selects FCVT.W.S, 1 selects FCVT.WU.S.
REQ-007 SHALL have port rm, input, 3: rounding mode, resolved upstream (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM).
REQ-008 SHALL have port flush, input, 1: synchronous abort of the operation in flight.
REQ-009 SHALL have port out_valid, output, 1: result available.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port int_out, output, 32: integer result.
REQ-012 SHALL have port fflags, output, 5: {NV,DZ,OF,UF,NX}; DZ, OF and UF are always 0.

Function
REQ-013 SHALL implement FSM states IDLE, UNPACK, SHIFT, ROUND, DONE.
REQ-014 SHALL assert in_ready only in IDLE; an accept is in_valid&in_ready, which registers float_in, is_unsigned and rm and moves to UNPACK.
REQ-015 SHALL sequence UNPACK->SHIFT->ROUND->DONE unconditionally, one state per cycle, so out_valid rises exactly 4 cycles after the accept edge.
REQ-016 UNPACK SHALL extract sign, exponent and {1,mantissa} and classify the operand as NaN, infinity, zero/denormal or normal.
REQ-017 SHALL shift the significand into a 32-bit integer part plus guard, round and sticky bits; exponent < 127-2 yields integer 0 with sticky = (operand nonzero).
REQ-018 ROUND SHALL add 1 to the magnitude when: RNE G&(R|S|lsb); RTZ never; RDN sign&(G|R|S); RUP ~sign&(G|R|S); RMM G.
REQ-019 SHALL treat any other rm encoding as RTZ.
REQ-020 SHALL negate the rounded magnitude when sign=1 and the result is in range.
REQ-021 Signed out-of-range, with NV=1: NaN or positive overflow -> 0x7FFFFFFF; negative overflow -> 0x80000000; exactly -2^31 is in range with no NV.
REQ-022 Unsigned out-of-range, with NV=1: NaN or positive overflow -> 0xFFFFFFFF; any negative value whose rounded magnitude is nonzero -> 0x00000000.
REQ-023 A negative value rounding to 0 in unsigned mode SHALL give 0 with NX only.
REQ-024 SHALL set NX when G|R|S is nonzero and NV=0, and SHALL never set NX together with NV.
REQ-025 Zero and denormal inputs SHALL produce 0; NX=1 for denormals.
REQ-026 In DONE, SHALL hold out_valid=1 with int_out and fflags stable until out_ready=1, then return to IDLE on that edge.
REQ-027 SHALL not accept a new operand in the same cycle a result is consumed (in_ready stays low in DONE).
REQ-028 flush=1 SHALL return the FSM to IDLE on the next edge from any state and deassert out_valid; flush takes priority over an accept or a consume in the same cycle.

Reset
REQ-029 Reset SHALL set the FSM to IDLE, in_ready=1, out_valid=0, int_out=0, fflags=0, and clear all operand registers.
REQ-030 Reset asserted mid-operation SHALL discard the operation, and no out_valid SHALL follow.

Configuration
REQ-031 Macro FCVT_FFLAGS_EN defined: fflags is computed per REQ-021 to REQ-025.
REQ-032 FCVT_FFLAGS_EN undefined: fflags is tied to 0 and the flag logic is removed; int_out and latency are unchanged.

Structure
REQ-033 Package fcvt_pkg SHALL hold the FSM state enum, the rm encoding constants, the saturation constants (0x7FFFFFFF, 0x80000000, 0xFFFFFFFF) and the fflags bit indices.
REQ-034 The increment decision of REQ-018 SHALL be a combinational sub-module f2i_round (inputs sign, lsb, G, R, S, rm; output inc).

Verification
REQ-035 0x40490FDB, signed, RNE, accept at cycle 0 -> out_valid at cycle 4, int_out=3, fflags=0x01.
REQ-036 0x3FC00000 RNE -> 2; 0x40200000 RNE -> 2; 0x40200000 RMM -> 3; 0xBFC00000 RDN -> 0xFFFFFFFE; all with NX.
REQ-037 0x4F000000 signed -> 0x7FFFFFFF, fflags=0x10; 0xCF000000 signed -> 0x80000000, fflags=0x00.
REQ-038 0x7FC00000 unsigned -> 0xFFFFFFFF, NV; 0xBF800000 unsigned -> 0, NV; 0xBE99999A unsigned RTZ -> 0, NX only.
REQ-039 out_ready held low 5 cycles in DONE -> int_out, fflags and out_valid stable and in_ready=0 throughout; consume -> in_ready=1 next cycle.
REQ-040 flush in SHIFT, or reset in ROUND -> no out_valid, IDLE next cycle; a following operand converts correctly.
